// File: rtl/grid_pkg.sv
// Shared definitions for the grid state writer.
//   - default grid geometry (GRID_W x GRID_H)
//   - command port field widths and opcode encoding
//   - IDLE/SWEEP state encoding
//   - idx_width(): index width that holds every cell number and every
//     coordinate the command port can express, so index math never wraps
package grid_pkg;

    localparam int unsigned GridWDefault = 4;
    localparam int unsigned GridHDefault = 3;

    localparam int unsigned XW  = 3;
    localparam int unsigned YW  = 2;
    localparam int unsigned RdW = 4;

    typedef enum logic [1:0] {
        OpClr      = 2'b00,
        OpSet      = 2'b01,
        OpToggle   = 2'b10,
        OpClearAll = 2'b11
    } grid_op_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StSweep = 1'b1
    } grid_state_e;

    function automatic int unsigned idx_width(input int unsigned w, input int unsigned h);
        int unsigned need;
        int unsigned span;
        need = $clog2(w * h) + 1;
        span = $clog2((2 ** XW - 1) + (2 ** YW - 1) * w + 1);
        if (span > need) need = span;
        if (RdW > need) need = RdW;
        return need;
    endfunction

endpackage

// File: rtl/grid_index.sv
// Coordinate-to-index conversion and range checks.
// Ports:
//   x, y      : command coordinates
//   lin       : display-side linear read index
//   index     : x + y*GRID_W at IDX_W bits
//   coord_ok  : x < GRID_W and y < GRID_H
//   lin_index : lin widened to IDX_W bits
//   lin_ok    : lin < GRID_W*GRID_H
module grid_index
    import grid_pkg::*;
#(
    parameter int unsigned GRID_W = GridWDefault,
    parameter int unsigned GRID_H = GridHDefault,
    parameter int unsigned IDX_W  = idx_width(GridWDefault, GridHDefault)
) (
    input  logic [XW-1:0]    x,
    input  logic [YW-1:0]    y,
    input  logic [RdW-1:0]   lin,
    output logic [IDX_W-1:0] index,
    output logic             coord_ok,
    output logic [IDX_W-1:0] lin_index,
    output logic             lin_ok
);

    localparam int unsigned N = GRID_W * GRID_H;

    assign index     = IDX_W'(x) + IDX_W'(y) * IDX_W'(GRID_W);
    assign coord_ok  = (32'(x) < GRID_W) && (32'(y) < GRID_H);
    assign lin_index = IDX_W'(lin);
    assign lin_ok    = 32'(lin) < N;

endmodule

// File: rtl/grid_state_writer.sv
// Grid cell state store with a valid/ready command port and a registered
// display read port.
// Optional feature macro: GRID_CLEAR_ALL_EN (compiles in the SWEEP state and
// its counter; without it CLEAR_ALL is rejected with an err pulse).
// Ports:
//   aclk, aresetn       : clock, asynchronous active-low reset
//   s_valid/s_ready     : command handshake
//   s_op, s_x, s_y      : opcode and target cell
//   rd_index, rd_state  : display read, one cycle latency, 0 when out of range
//   busy                : CLEAR_ALL sweep in progress
//   err                 : one-cycle pulse after a rejected command
module grid_state_writer
    import grid_pkg::*;
#(
    parameter int unsigned GRID_W = GridWDefault,
    parameter int unsigned GRID_H = GridHDefault
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [1:0]     s_op,
    input  logic [XW-1:0]  s_x,
    input  logic [YW-1:0]  s_y,
    input  logic [RdW-1:0] rd_index,
    output logic           rd_state,
    output logic           busy,
    output logic           err
);

    localparam int unsigned N    = GRID_W * GRID_H;
    localparam int unsigned IdxW = idx_width(GRID_W, GRID_H);

    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;
    logic            coord_ok;
    logic            rd_ok;

    grid_index #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .IDX_W  (IdxW)
    ) u_index (
        .x         (s_x),
        .y         (s_y),
        .lin       (rd_index),
        .index     (wr_idx),
        .coord_ok  (coord_ok),
        .lin_index (rd_idx),
        .lin_ok    (rd_ok)
    );

    logic [N-1:0]    cells_q, cells_d;
    logic            rd_q, rd_d;
    logic            err_q, err_d;
    logic            live_q;   // low until the first edge after reset release
    logic            in_idle;
    logic            accept;
    logic            sweep_clr;
    logic [IdxW-1:0] sweep_idx;
    logic            clear_all_ok;
    grid_op_e        op;

    assign op      = grid_op_e'(s_op);
    assign s_ready = live_q & in_idle;
    assign accept  = s_valid & s_ready;

`ifdef GRID_CLEAR_ALL_EN
    grid_state_e     state_q, state_d;
    logic [IdxW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept && op == OpClearAll) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            StSweep: begin
                if (cnt_q == IdxW'(N - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_idle      = (state_q == StIdle);
    assign busy         = (state_q == StSweep);
    assign sweep_clr    = busy;
    assign sweep_idx    = cnt_q;
    assign clear_all_ok = 1'b1;
`else
    assign in_idle      = 1'b1;
    assign busy         = 1'b0;
    assign sweep_clr    = 1'b0;
    assign sweep_idx    = '0;
    assign clear_all_ok = 1'b0;
`endif

    always_comb begin
        cells_d = cells_q;
        err_d   = 1'b0;
        if (sweep_clr) begin
            cells_d = cells_q & ~(N'(1) << sweep_idx);
        end else if (accept) begin
            if (op == OpClearAll) begin
                // The sweep itself clears cells; here only the rejection matters.
                err_d = ~clear_all_ok;
            end else if (!coord_ok) begin
                err_d = 1'b1;
            end else begin
                case (op)
                    OpClr:    cells_d = cells_q & ~(N'(1) << wr_idx);
                    OpSet:    cells_d = cells_q | (N'(1) << wr_idx);
                    OpToggle: cells_d = cells_q ^ (N'(1) << wr_idx);
                    default:  cells_d = cells_q;
                endcase
            end
        end
    end

    // Read from the current (pre-write) array so a same-edge write shows the old value.
    logic [N-1:0] rd_shift;
    always_comb begin
        rd_shift = cells_q >> rd_idx;
        rd_d     = rd_ok & rd_shift[0];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cells_q <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            cells_q <= cells_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    assign rd_state = rd_q;
    assign err      = err_q;

endmodule

// File: tb/tb_grid_state_writer.sv
module tb_grid_state_writer;

    localparam int GW = 4;
    localparam int GH = 3;
    localparam int NC = GW * GH;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] s_op = 2'b00;
    logic [2:0] s_x = 3'd0;
    logic [1:0] s_y = 2'd0;
    logic [3:0] rd_index = 4'd0;
    logic       rd_state;
    logic       busy;
    logic       err;

    int pass_cnt = 0;
    int total_cnt = 0;

    bit model [NC];

    grid_state_writer dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_op     (s_op),
        .s_x      (s_x),
        .s_y      (s_y),
        .rd_index (rd_index),
        .rd_state (rd_state),
        .busy     (busy),
        .err      (err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1);
    end

    // Reference rules: returns whether the command is rejected, updates the model.
    function automatic bit model_apply(input int op, input int x, input int y);
        int idx;
        if (op == 3) begin
`ifdef GRID_CLEAR_ALL_EN
            for (int i = 0; i < NC; i++) model[i] = 1'b0;
            return 1'b0;
`else
            return 1'b1;
`endif
        end
        if (x >= GW || y >= GH) return 1'b1;
        idx = x + y * GW;
        if (op == 0) model[idx] = 1'b0;
        else if (op == 1) model[idx] = 1'b1;
        else model[idx] = !model[idx];
        return 1'b0;
    endfunction

    function automatic bit model_rd(input int r);
        if (r >= NC) return 1'b0;
        return model[r];
    endfunction

    task automatic do_reset();
        s_valid = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        for (int i = 0; i < NC; i++) model[i] = 1'b0;
    endtask

    // One accepted command (assumes s_ready is high); leaves us #1 after the edge.
    task automatic send(input int op, input int x, input int y);
        s_valid = 1'b1;
        s_op = 2'(op);
        s_x = 3'(x);
        s_y = 2'(y);
        @(posedge aclk);
        #1 s_valid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_valid = 1'b1;
        s_op = 2'b01;
        repeat (3) @(posedge aclk);
        #1;
        total_cnt++;
        if (s_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", s_ready);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || err !== 1'b0 || rd_state !== 1'b0)
            $display("FAIL reset_outs: busy/err/rd got %b%b%b want 000", busy, err, rd_state);
        else pass_cnt++;
        s_valid = 1'b0;
        aresetn = 1'b1;
        #1;
        total_cnt++;
        if (s_ready !== 1'b0) $display("FAIL release_ready_early: got %b want 0", s_ready);
        else pass_cnt++;
        @(posedge aclk);
        #1;
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", s_ready);
        else pass_cnt++;
        for (int i = 0; i < NC; i++) model[i] = 1'b0;
        for (int i = 0; i < NC; i++) begin
            rd_index = 4'(i);
            @(posedge aclk);
            #1;
            total_cnt++;
            if (rd_state !== 1'b0) $display("FAIL reset_cell%0d: got %b want 0", i, rd_state);
            else pass_cnt++;
        end
    endtask

    task automatic test_set_read();
        rd_index = 4'd11;
        send(1, 3, 2);
        void'(model_apply(1, 3, 2));
        total_cnt++;
        if (rd_state !== 1'b0) $display("FAIL set_old_value: got %b want 0", rd_state);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL set_err: got %b want 0", err);
        else pass_cnt++;
        @(posedge aclk);
        #1;
        total_cnt++;
        if (rd_state !== 1'b1) $display("FAIL set_cell11: got %b want 1", rd_state);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL set_err_after: got %b want 0", err);
        else pass_cnt++;
        rd_index = 4'd12;
        @(posedge aclk);
        #1;
        total_cnt++;
        if (rd_state !== 1'b0) $display("FAIL rd_out_of_range: got %b want 0", rd_state);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        rd_index = 4'd5;
        s_valid = 1'b1;
        s_op = 2'b10;
        s_x = 3'd1;
        s_y = 2'd1;
        #1;
        total_cnt++;
        if (s_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", s_ready);
        else pass_cnt++;
        @(posedge aclk);
        #1;
        total_cnt++;
        if (s_ready !== 1'b1 || rd_state !== 1'b0)
            $display("FAIL b2b_first: ready/rd got %b%b want 10", s_ready, rd_state);
        else pass_cnt++;
        @(posedge aclk);
        #1 s_valid = 1'b0;
        total_cnt++;
        if (s_ready !== 1'b1 || rd_state !== 1'b1)
            $display("FAIL b2b_second: ready/rd got %b%b want 11", s_ready, rd_state);
        else pass_cnt++;
        @(posedge aclk);
        #1;
        total_cnt++;
        if (rd_state !== 1'b0) $display("FAIL b2b_final: got %b want 0", rd_state);
        else pass_cnt++;
        void'(model_apply(2, 1, 1));
        void'(model_apply(2, 1, 1));
    endtask

    task automatic test_out_of_range();
        int xs [2] = '{4, 0};
        int ys [2] = '{0, 3};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            send(1, xs[k], ys[k]);
            total_cnt++;
            if (err !== 1'b1) $display("FAIL oor_err%0d: got %b want 1", k, err);
            else pass_cnt++;
            @(posedge aclk);
            #1;
            total_cnt++;
            if (err !== 1'b0) $display("FAIL oor_err_drop%0d: got %b want 0", k, err);
            else pass_cnt++;
        end
        for (int i = 0; i < NC; i++) begin
            rd_index = 4'(i);
            @(posedge aclk);
            #1;
            total_cnt++;
            if (rd_state !== 1'b0) $display("FAIL oor_cell%0d: got %b want 0", i, rd_state);
            else pass_cnt++;
        end
    endtask

`ifdef GRID_CLEAR_ALL_EN
    task automatic test_clear_all();
        for (int i = 0; i < NC; i++) begin
            send(1, i % GW, i / GW);
            void'(model_apply(1, i % GW, i / GW));
        end
        rd_index = 4'd6;
        send(3, 7, 3);
        void'(model_apply(3, 0, 0));
        // Offer a SET during the sweep; it must wait.
        s_valid = 1'b1;
        s_op = 2'b01;
        s_x = 3'd2;
        s_y = 2'd1;
        for (int k = 0; k < NC; k++) begin
            total_cnt++;
            if (busy !== 1'b1 || s_ready !== 1'b0)
                $display("FAIL sweep_cyc%0d: busy/ready got %b%b want 10", k, busy, s_ready);
            else pass_cnt++;
            @(posedge aclk);
            #1;
        end
        total_cnt++;
        if (busy !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL sweep_end: busy/ready got %b%b want 01", busy, s_ready);
        else pass_cnt++;
        @(posedge aclk);
        #1 s_valid = 1'b0;
        total_cnt++;
        if (rd_state !== 1'b0) $display("FAIL pending_before: got %b want 0", rd_state);
        else pass_cnt++;
        void'(model_apply(1, 2, 1));
        for (int i = 0; i < NC; i++) begin
            rd_index = 4'(i);
            @(posedge aclk);
            #1;
            total_cnt++;
            if (rd_state !== model[i])
                $display("FAIL clear_cell%0d: got %b want %b", i, rd_state, model[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 8; i < NC; i++) send(1, i % GW, i / GW);
        send(3, 0, 0);
        repeat (5) @(posedge aclk);
        #1 aresetn = 1'b0;
        #2;
        total_cnt++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || rd_state !== 1'b0)
            $display("FAIL midsweep_reset: ready/busy/err/rd got %b%b%b%b want 0000",
                     s_ready, busy, err, rd_state);
        else pass_cnt++;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        total_cnt++;
        if (s_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL midsweep_release: ready/busy got %b%b want 10", s_ready, busy);
        else pass_cnt++;
        for (int i = 0; i < NC; i++) model[i] = 1'b0;
        for (int i = 0; i < NC; i++) begin
            rd_index = 4'(i);
            @(posedge aclk);
            #1;
            total_cnt++;
            if (rd_state !== 1'b0) $display("FAIL midsweep_cell%0d: got %b want 0", i, rd_state);
            else pass_cnt++;
        end
    endtask
`else
    task automatic test_clear_all_disabled();
        send(1, 0, 0);
        send(1, 2, 2);
        void'(model_apply(1, 0, 0));
        void'(model_apply(1, 2, 2));
        send(3, 1, 1);
        total_cnt++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL clrall_off: err/busy got %b%b want 10", err, busy);
        else pass_cnt++;
        for (int i = 0; i < NC; i++) begin
            rd_index = 4'(i);
            @(posedge aclk);
            #1;
            total_cnt++;
            if (rd_state !== model[i] || busy !== 1'b0)
                $display("FAIL clrall_off_cell%0d: rd/busy got %b%b want %b0",
                         i, rd_state, busy, model[i]);
            else pass_cnt++;
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int op;
            int x;
            int y;
            int r;
            bit v;
            bit exp_err;
            bit exp_rd;
            v = ($urandom_range(0, 3) != 0);
`ifdef GRID_CLEAR_ALL_EN
            op = $urandom_range(0, 2);
`else
            op = $urandom_range(0, 3);
`endif
            x = $urandom_range(0, 4);
            y = $urandom_range(0, 3);
            r = $urandom_range(0, 15);
            s_valid = v;
            s_op = 2'(op);
            s_x = 3'(x);
            s_y = 2'(y);
            rd_index = 4'(r);
            exp_rd = model_rd(r);
            exp_err = v ? model_apply(op, x, y) : 1'b0;
            @(posedge aclk);
            #1;
            total_cnt++;
            if (err !== exp_err || rd_state !== exp_rd || s_ready !== 1'b1)
                $display("FAIL rand%0d op%0d x%0d y%0d rd%0d: err/rd/ready got %b%b%b want %b%b1",
                         n, op, x, y, r, err, rd_state, s_ready, exp_err, exp_rd);
            else pass_cnt++;
        end
        s_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_set_read();
        test_back_to_back();
        test_out_of_range();
`ifdef GRID_CLEAR_ALL_EN
        test_clear_all();
        test_reset_mid_sweep();
`else
        test_clear_all_disabled();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/grid_state_writer.md
GRID_STATE_WRITER -- requirements
Module: grid_state_writer

Interface
REQ-001 SHALL have parameter GRID_W, default 4, grid columns.
REQ-002 SHALL have parameter GRID_H, default 3, grid rows; cell count N = GRID_W*GRID_H, default 12.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port s_valid, input, 1, command valid.
REQ-006 SHALL have port s_ready, output, 1, command ready.
REQ-007 SHALL have port s_op, input, 2, opcode: 00 CLR_CELL, 01 SET_CELL, 10 TOGGLE_CELL, 11 CLEAR_ALL.
REQ-008 SHALL have port s_x, input, 3, target column.
REQ-009 SHALL have port s_y, input, 2, target row.
REQ-010 SHALL have port rd_index, input, 4, display read index, computed as x + y*GRID_W.
REQ-011 SHALL have port rd_state, output, 1, registered state of cell rd_index.
REQ-012 SHALL have port busy, output, 1, high while a CLEAR_ALL sweep runs.
REQ-013 SHALL have port err, output, 1, one-cycle pulse when a command is rejected.

Function
REQ-014 SHALL hold N state bits in a register array, indexed as x + y*GRID_W.
REQ-015 SHALL use a state machine with two states: IDLE and SWEEP.
REQ-016 SHALL drive s_ready = 1 only in IDLE while aresetn is high; a command is accepted on the edge where s_valid and s_ready are both 1.
REQ-017 SHALL commit an accepted CLR, SET or TOGGLE on the accepting edge, so the new value is visible in the array in the next cycle.
REQ-018 SHALL reject a command with s_x >= GRID_W or s_y >= GRID_H: the command is accepted, the array is unchanged, and err is 1 for the following cycle.
REQ-019 SHALL handle an accepted CLEAR_ALL as follows: enter SWEEP, zero one cell per cycle in order 0..N-1, then return to IDLE after cell N-1 is cleared; s_x and s_y are ignored.
REQ-020 SHALL hold s_ready = 0 and busy = 1 for exactly N cycles during SWEEP; commands offered during SWEEP remain pending until IDLE.
REQ-021 SHALL update rd_state every cycle from array[rd_index] with 1-cycle latency.
REQ-022 SHALL drive rd_state = 0 when rd_index >= N.
REQ-023 SHALL give rd_state the pre-write (old) value when rd_index addresses the cell being written on the same edge.
REQ-024 SHALL accept back-to-back commands in IDLE, one per cycle; a toggle of the same cell on consecutive cycles yields 1 then 0.
REQ-025 SHALL compute all index arithmetic at a width of at least clog2(N)+1 bits, with no wrap-around.

Reset
REQ-026 SHALL, while aresetn is low: all cells 0, rd_state 0, busy 0, err 0, state IDLE, s_ready 0, sweep counter 0.
REQ-027 SHALL abort a sweep immediately if reset is asserted mid-SWEEP; the array is 0 at reset release.
REQ-028 SHALL raise s_ready on the first aclk edge after aresetn deasserts.

Configuration
REQ-029 SHALL use macro GRID_CLEAR_ALL_EN to compile the SWEEP state and its counter in or out.
REQ-030 SHALL, when GRID_CLEAR_ALL_EN is defined, implement CLEAR_ALL as in REQ-019 and REQ-020.
REQ-031 SHALL, when GRID_CLEAR_ALL_EN is undefined: op 11 is accepted, pulses err, leaves the array unchanged, and busy is tied to 0.

Structure
REQ-032 SHALL place GRID_W and GRID_H defaults, opcode constants and the IDLE/SWEEP state encoding in shared package grid_pkg.
REQ-033 SHALL place the coordinate-to-index conversion and range check in sub-module grid_index, reused by display-side logic.

Verification
REQ-034 SHALL cover: reset, then SET (x=3, y=2) -> cell 11 = 1; rd_index=11 gives rd_state=1 one cycle later; err stays 0.
REQ-035 SHALL cover: TOGGLE (1,1) on two consecutive cycles -> cell 5 reads 1, then 0; s_ready stays 1 throughout.
REQ-036 SHALL cover: SET (4,0) and SET (0,3) -> each gives a one-cycle err pulse; all 12 cells remain 0.
REQ-037 SHALL cover: all cells SET, then CLEAR_ALL -> busy=1 and s_ready=0 for 12 cycles; all cells 0 afterwards; a SET held pending during the sweep commits only after the sweep ends.
REQ-038 SHALL cover: aresetn low at sweep cycle 5 -> all outputs at reset values; s_ready=1 one edge after release.
REQ-039 SHALL cover: build with GRID_CLEAR_ALL_EN undefined, issue op 11 -> err pulses, the array is unchanged, busy=0.
